// File: rtl/axis_nibble_packer.sv
// Purpose : packs LSB-aligned, nibble-granular AXI-Stream beats into dense full-width words.
// Latency : a full word is registered one cycle after the accumulator holds DATA_WIDTH bits.
// Backpr. : s_axis_tready drops when the accumulator cannot take a full beat; m_axis_* hold while stalled.
//
// Ports:
//   clk, areset                   single clock, asynchronous active-high reset
//   s_axis_tdata/tkeep/tlast      input beat; tkeep = number of valid bits (multiple of 4)
//   s_axis_tvalid/tready          input handshake
//   m_axis_tdata/tkeep/tlast      registered packed output; tkeep = valid bit count
//   m_axis_tvalid/tready          output handshake
//   err                           sticky protocol error (only when AXIS_NIBBLE_PACKER_ERR_EN is defined)
//
// Build option: define AXIS_NIBBLE_PACKER_ERR_EN to build the tkeep protocol checker behind err.
module axis_nibble_packer #(
    parameter int DATA_WIDTH = 16,
    parameter int KEEP_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  areset,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  err
);

    localparam int AW = 2 * DATA_WIDTH;
    localparam int FW = $clog2(AW + 1);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         acc_q, acc_d;
    logic [FW-1:0]         fill_q, fill_d;
    logic [DATA_WIDTH-1:0] m_dat_q, m_dat_d;
    logic [KEEP_WIDTH-1:0] m_keep_q, m_keep_d;
    logic                  m_vld_q, m_vld_d;
    logic                  m_last_q, m_last_d;

    logic                  load;
    logic                  s_rdy;
    logic                  accept;
    logic                  drain;
    logic [KEEP_WIDTH-1:0] keep_rd;
    logic [FW-1:0]         keep_s;
    logic [AW-1:0]         in_ext;
    logic [AW-1:0]         acc_pd;
    logic [FW-1:0]         fill_pd;
    logic [AW-1:0]         acc_acc;
    logic [FW-1:0]         fill_acc;

    always_comb begin
        load     = !m_vld_q || m_axis_tready;

        // Sanitise tkeep: round down to a nibble, clamp to one beat.
        keep_rd  = s_axis_tkeep & ~KEEP_WIDTH'(3);
        keep_s   = (keep_rd > KEEP_WIDTH'(DATA_WIDTH)) ? FW'(DATA_WIDTH) : FW'(keep_rd);
        in_ext   = {{DATA_WIDTH{1'b0}}, s_axis_tdata} & ~({AW{1'b1}} << keep_s);

        // Ready only from registered state: either the beat fits now, or a
        // drain this cycle makes room (fill - DATA_WIDTH + DATA_WIDTH <= 2*DATA_WIDTH).
        s_rdy    = !areset && (state_q == RUN) && ((fill_q <= FW'(DATA_WIDTH)) || load);
        accept   = s_axis_tvalid && s_rdy;
        drain    = (state_q == RUN) && load && (fill_q >= FW'(DATA_WIDTH));

        // Drain happens first; the accepted beat lands at the post-drain fill.
        acc_pd   = drain ? (acc_q >> DATA_WIDTH) : acc_q;
        fill_pd  = drain ? (fill_q - FW'(DATA_WIDTH)) : fill_q;
        acc_acc  = accept ? (acc_pd | (in_ext << fill_pd)) : acc_pd;
        fill_acc = accept ? (fill_pd + keep_s) : fill_pd;

        state_d  = state_q;
        acc_d    = acc_q;
        fill_d   = fill_q;
        m_dat_d  = m_dat_q;
        m_keep_d = m_keep_q;
        m_vld_d  = m_vld_q;
        m_last_d = m_last_q;

        case (state_q)
            RUN: begin
                acc_d  = acc_acc;
                fill_d = fill_acc;
                if (drain) begin
                    m_vld_d  = 1'b1;
                    m_dat_d  = acc_q[DATA_WIDTH-1:0];
                    m_keep_d = KEEP_WIDTH'(DATA_WIDTH);
                    // A tlast beat that empties the accumulator rides on this word.
                    m_last_d = accept && s_axis_tlast && (fill_acc == '0);
                end else if (load) begin
                    m_vld_d  = 1'b0;
                end
                if (accept && s_axis_tlast && !(drain && (fill_acc == '0))) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (load) begin
                    m_vld_d = 1'b1;
                    m_dat_d = acc_q[DATA_WIDTH-1:0];
                    if (fill_q > FW'(DATA_WIDTH)) begin
                        m_keep_d = KEEP_WIDTH'(DATA_WIDTH);
                        m_last_d = 1'b0;
                        acc_d    = acc_q >> DATA_WIDTH;
                        fill_d   = fill_q - FW'(DATA_WIDTH);
                    end else begin
                        // Bits above fill are always zero, so the tail needs no masking.
                        // fill == 0 here yields the zero-length terminator.
                        m_keep_d = KEEP_WIDTH'(fill_q);
                        m_last_d = 1'b1;
                        acc_d    = '0;
                        fill_d   = '0;
                        state_d  = RUN;
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q  <= RUN;
            acc_q    <= '0;
            fill_q   <= '0;
            m_dat_q  <= '0;
            m_keep_q <= '0;
            m_vld_q  <= 1'b0;
            m_last_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            fill_q   <= fill_d;
            m_dat_q  <= m_dat_d;
            m_keep_q <= m_keep_d;
            m_vld_q  <= m_vld_d;
            m_last_q <= m_last_d;
        end
    end

    assign s_axis_tready = s_rdy;
    assign m_axis_tdata  = m_dat_q;
    assign m_axis_tkeep  = m_keep_q;
    assign m_axis_tvalid = m_vld_q;
    assign m_axis_tlast  = m_last_q;

`ifdef AXIS_NIBBLE_PACKER_ERR_EN
    logic err_q;
    logic bad_keep;

    // Flags a non-nibble or oversize count, or an empty beat that does not close a packet.
    assign bad_keep = (s_axis_tkeep[1:0] != 2'b00) ||
                      (s_axis_tkeep > KEEP_WIDTH'(DATA_WIDTH)) ||
                      ((s_axis_tkeep == '0) && !s_axis_tlast);

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            err_q <= 1'b0;
        end else if (accept && bad_keep) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
